// File: rtl/spell_trace_generator.sv
// Target spell trace generator: picks an origin cell on the 4x4 grid and reveals
// an adjacent-cell random walk one cell per STEP_CYCLES, then holds it for scoring.
module spell_trace_generator #(
  parameter int unsigned STEP_CYCLES = 25000000,
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned TRACE_LEN   = 6,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        learn_mode,
  input  logic [4:0]  origin_sel,
  output logic [15:0] displayed_trace,
  output logic        reset_trace,
  output logic [5:0]  origin,
  output logic [5:0]  next,
  output logic        trace_visible,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state_dbg
);

  localparam int unsigned TMAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int TW = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_STEP  = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0]    count_q, count_d;
  logic [15:0]   trace_q, trace_d;
  logic [3:0]    origin_q, origin_d;
  logic [3:0]    next_q, next_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic          lfsr_fb;
  logic [4:0]    probe_r;
  logic          step_found;
  logic [3:0]    step_cell;
  logic [3:0]    origin_pick;

  // Returns {legal, target}: legal when the move stays on the grid without
  // row wrap and lands on a cell that is not yet part of the trace.
  function automatic logic [4:0] probe(input logic [3:0] c, input logic [1:0] dir,
                                       input logic [15:0] tr);
    logic [3:0] t;
    logic       on_grid;
    t       = c;
    on_grid = 1'b0;
    case (dir)
      2'd0:    begin on_grid = (c > 4'd3);         t = c - 4'd4; end
      2'd1:    begin on_grid = (c[1:0] != 2'd3);   t = c + 4'd1; end
      2'd2:    begin on_grid = (c < 4'd12);        t = c + 4'd4; end
      default: begin on_grid = (c[1:0] != 2'd0);   t = c - 4'd1; end
    endcase
    return {on_grid && !tr[t], t};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      lfsr_q   <= LFSR_SEED;
      timer_q  <= '0;
      count_q  <= '0;
      trace_q  <= '0;
      origin_q <= '0;
      next_q   <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      count_q  <= count_d;
      trace_q  <= trace_d;
      origin_q <= origin_d;
      next_q   <= next_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    state_d     = state_q;
    lfsr_d      = {lfsr_fb, lfsr_q[15:1]};
    timer_d     = timer_q;
    count_d     = count_q;
    trace_d     = trace_q;
    origin_d    = origin_q;
    next_d      = next_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    probe_r     = '0;
    step_found  = 1'b0;
    step_cell   = '0;
    origin_pick = origin_sel[4] ? origin_sel[3:0] : lfsr_q[3:0];

    // Preferred direction first, then rotate clockwise through the rest.
    for (int i = 0; i < 4; i++) begin
      probe_r = probe(next_q, lfsr_q[1:0] + 2'(i), trace_q);
      if (!step_found && probe_r[4]) begin
        step_found = 1'b1;
        step_cell  = probe_r[3:0];
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CLEAR;
          trace_d = '0;
          valid_d = 1'b0;
        end
      end
      S_CLEAR: begin
        trace_d  = 16'd1 << origin_pick;
        origin_d = origin_pick;
        next_d   = origin_pick;
        valid_d  = 1'b1;
        count_d  = 5'd1;
        timer_d  = '0;
        state_d  = S_STEP;
      end
      S_STEP: begin
        if (timer_q == TW'(STEP_CYCLES - 1)) begin
          timer_d = '0;
          if (step_found) begin
            trace_d = trace_q | (16'd1 << step_cell);
            next_d  = step_cell;
            count_d = count_q + 5'd1;
            if (count_q + 5'd1 == 5'(TRACE_LEN)) state_d = S_HOLD;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_HOLD: begin
        if (learn_mode) begin
          timer_d = '0;
        end else if (timer_q == TW'(HOLD_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    displayed_trace = trace_q;
    reset_trace     = (state_q == S_CLEAR);
    origin          = valid_q ? {2'b00, origin_q} : 6'h3F;
    next            = valid_q ? {2'b00, next_q} : 6'h3F;
    trace_visible   = (state_q == S_STEP) || (state_q == S_HOLD);
    busy            = (state_q == S_CLEAR) || (state_q == S_STEP) || (state_q == S_HOLD);
    done            = done_q;
    state_dbg       = state_q;
  end

endmodule

// File: tb/tb_spell_trace_generator.sv
// Bench for spell_trace_generator: three instances with different timing/length
// parameters, each checked against a grid-walk reference model.
module tb_spell_trace_generator;

  localparam int NI = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[NI], start[NI], learn[NI];
  logic [4:0]  osel[NI];
  logic [15:0] disp[NI];
  logic        rt[NI], vis[NI], bsy[NI], dn[NI];
  logic [5:0]  org[NI], nxt[NI];
  logic [2:0]  st[NI];
  logic [15:0] lfsr_m[NI];

  int errors = 0;
  int checks = 0;

  spell_trace_generator #(.STEP_CYCLES(4), .HOLD_CYCLES(8), .TRACE_LEN(6), .LFSR_SEED(SEED)) u0 (
    .clk(clk), .reset(rst[0]), .start(start[0]), .learn_mode(learn[0]), .origin_sel(osel[0]),
    .displayed_trace(disp[0]), .reset_trace(rt[0]), .origin(org[0]), .next(nxt[0]),
    .trace_visible(vis[0]), .busy(bsy[0]), .done(dn[0]), .state_dbg(st[0]));

  spell_trace_generator #(.STEP_CYCLES(1), .HOLD_CYCLES(1), .TRACE_LEN(16), .LFSR_SEED(SEED)) u1 (
    .clk(clk), .reset(rst[1]), .start(start[1]), .learn_mode(learn[1]), .origin_sel(osel[1]),
    .displayed_trace(disp[1]), .reset_trace(rt[1]), .origin(org[1]), .next(nxt[1]),
    .trace_visible(vis[1]), .busy(bsy[1]), .done(dn[1]), .state_dbg(st[1]));

  spell_trace_generator #(.STEP_CYCLES(2), .HOLD_CYCLES(5), .TRACE_LEN(2), .LFSR_SEED(SEED)) u2 (
    .clk(clk), .reset(rst[2]), .start(start[2]), .learn_mode(learn[2]), .origin_sel(osel[2]),
    .displayed_trace(disp[2]), .reset_trace(rt[2]), .origin(org[2]), .next(nxt[2]),
    .trace_visible(vis[2]), .busy(bsy[2]), .done(dn[2]), .state_dbg(st[2]));

  function automatic int step_c(input int k);
    case (k) 0: return 4; 1: return 1; default: return 2; endcase
  endfunction
  function automatic int hold_c(input int k);
    case (k) 0: return 8; 1: return 1; default: return 5; endcase
  endfunction
  function automatic int len_c(input int k);
    case (k) 0: return 6; 1: return 16; default: return 2; endcase
  endfunction

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    logic b;
    b = x[0] ^ x[2] ^ x[3] ^ x[5];
    return {b, x[15:1]};
  endfunction

  // Grid move in row/column terms: returns target cell or -1 if off-grid or taken.
  function automatic int try_move(input int c, input int d, input logic [15:0] tr);
    int r, col, nr, nc;
    r = c / 4; col = c % 4; nr = r; nc = col;
    case (d)
      0: nr = r - 1;
      1: nc = col + 1;
      2: nr = r + 1;
      default: nc = col - 1;
    endcase
    if (nr < 0 || nr > 3 || nc < 0 || nc > 3) return -1;
    if (tr[nr*4+nc]) return -1;
    return nr*4 + nc;
  endfunction

  always @(posedge clk)
    for (int k = 0; k < NI; k++) lfsr_m[k] <= rst[k] ? SEED : lfsr_adv(lfsr_m[k]);

  // Start a trace from IDLE/DONE and follow it to the first HOLD cycle.
  task automatic walk(input int k, input logic [4:0] s, input logic keep_start,
                      output logic [15:0] tr, output int cnt);
    int c, t;
    start[k] = 1'b1;
    osel[k]  = s;
    @(negedge clk);
    start[k] = keep_start;
    checks++;
    if (rt[k] !== 1'b1 || disp[k] !== 16'h0 || bsy[k] !== 1'b1 || vis[k] !== 1'b0) begin
      errors++;
      $display("FAIL clear_cycle[%0d]: reset_trace=%b trace=%h busy=%b vis=%b, required 1 0000 1 0",
               k, rt[k], disp[k], bsy[k], vis[k]);
    end
    c = s[4] ? int'(s[3:0]) : int'(lfsr_m[k][3:0]);
    tr = 16'h0;
    tr[c] = 1'b1;
    cnt = 1;
    @(negedge clk);
    checks++;
    if (rt[k] !== 1'b0 || disp[k] !== tr || org[k] !== {2'b00, 4'(c)} ||
        nxt[k] !== {2'b00, 4'(c)} || vis[k] !== 1'b1) begin
      errors++;
      $display("FAIL origin[%0d]: rt=%b trace=%h origin=%h next=%h vis=%b, required 0 %h %h %h 1",
               k, rt[k], disp[k], org[k], nxt[k], vis[k], tr, c, c);
    end
    while (cnt < len_c(k)) begin
      for (int i = 1; i < step_c(k); i++) begin
        @(negedge clk);
        checks++;
        if (disp[k] !== tr || rt[k] !== 1'b0 || vis[k] !== 1'b1) begin
          errors++;
          $display("FAIL step_wait[%0d]: trace=%h rt=%b vis=%b, required %h 0 1", k, disp[k], rt[k], vis[k], tr);
        end
      end
      t = -1;
      for (int i = 0; i < 4 && t < 0; i++)
        t = try_move(c, (int'(lfsr_m[k][1:0]) + i) % 4, tr);
      @(negedge clk);
      if (t < 0) begin
        checks++;
        if (disp[k] !== tr || vis[k] !== 1'b1 || bsy[k] !== 1'b1 || nxt[k] !== {2'b00, 4'(c)}) begin
          errors++;
          $display("FAIL dead_end[%0d]: trace=%h vis=%b busy=%b next=%h, required %h 1 1 %h",
                   k, disp[k], vis[k], bsy[k], nxt[k], tr, c);
        end
        break;
      end
      tr[t] = 1'b1;
      cnt++;
      c = t;
      checks++;
      if (disp[k] !== tr || nxt[k] !== {2'b00, 4'(t)} || rt[k] !== 1'b0 || vis[k] !== 1'b1) begin
        errors++;
        $display("FAIL step[%0d]: trace=%h next=%h rt=%b vis=%b, required %h %h 0 1",
                 k, disp[k], nxt[k], rt[k], vis[k], tr, t);
      end
    end
  endtask

  // From the first HOLD cycle with learn low: expect done exactly HOLD cycles later.
  task automatic finish_hold(input int k, input logic [15:0] tr);
    for (int i = 1; i < hold_c(k); i++) begin
      @(negedge clk);
      checks++;
      if (dn[k] !== 1'b0 || vis[k] !== 1'b1 || disp[k] !== tr) begin
        errors++;
        $display("FAIL hold[%0d]: done=%b vis=%b trace=%h, required 0 1 %h", k, dn[k], vis[k], disp[k], tr);
      end
    end
    @(negedge clk);
    checks++;
    if (dn[k] !== 1'b1 || vis[k] !== 1'b0 || bsy[k] !== 1'b0 || disp[k] !== tr) begin
      errors++;
      $display("FAIL done_entry[%0d]: done=%b vis=%b busy=%b trace=%h, required 1 0 0 %h",
               k, dn[k], vis[k], bsy[k], disp[k], tr);
    end
    @(negedge clk);
    checks++;
    if (dn[k] !== 1'b0 || disp[k] !== tr || org[k] === 6'h3F) begin
      errors++;
      $display("FAIL done_pulse[%0d]: done=%b trace=%h origin=%h, required 0 %h valid", k, dn[k], disp[k], org[k], tr);
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; start[k] = 1'b0; learn[k] = 1'b0; osel[k] = 5'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (disp[k] !== 16'h0 || rt[k] !== 1'b0 || org[k] !== 6'h3F || nxt[k] !== 6'h3F ||
          vis[k] !== 1'b0 || bsy[k] !== 1'b0 || dn[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: trace=%h rt=%b origin=%h next=%h vis=%b busy=%b done=%b, required 0 0 3f 3f 0 0 0",
                 k, disp[k], rt[k], org[k], nxt[k], vis[k], bsy[k], dn[k]);
      end
      rst[k] = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_first_trace();
    logic [15:0] tr;
    int cnt;
    walk(0, 5'h15, 1'b0, tr, cnt);
    checks++;
    if (disp[0] !== tr || !tr[5]) begin
      errors++;
      $display("FAIL first_trace: trace=%h, required %h containing cell 5", disp[0], tr);
    end
    finish_hold(0, tr);
  endtask

  task automatic test_corner();
    logic [15:0] tr;
    int cnt;
    walk(2, 5'h1F, 1'b0, tr, cnt);
    checks++;
    if (disp[2] !== 16'h8800 && disp[2] !== 16'hC000) begin
      errors++;
      $display("FAIL corner_second: trace=%h, required 8800 or c000", disp[2]);
    end
    finish_hold(2, tr);
  endtask

  task automatic test_random_walks();
    logic [15:0] tr;
    int cnt;
    for (int n = 0; n < 200; n++) begin
      walk(1, 5'($urandom_range(0, 31)), 1'b0, tr, cnt);
      checks++;
      if ($countones(disp[1]) != cnt || vis[1] !== 1'b1) begin
        errors++;
        $display("FAIL walk_popcount[%0d]: popcount=%0d vis=%b, required %0d 1", n, $countones(disp[1]), vis[1], cnt);
      end
      finish_hold(1, tr);
    end
  endtask

  task automatic test_learn();
    logic [15:0] tr;
    int cnt;
    learn[0] = 1'b1;
    walk(0, 5'($urandom_range(0, 31)), 1'b0, tr, cnt);
    for (int i = 0; i < 10 * hold_c(0); i++) begin
      @(negedge clk);
      checks++;
      if (vis[0] !== 1'b1 || bsy[0] !== 1'b1 || dn[0] !== 1'b0 || disp[0] !== tr) begin
        errors++;
        $display("FAIL learn_hold[%0d]: vis=%b busy=%b done=%b trace=%h, required 1 1 0 %h",
                 i, vis[0], bsy[0], dn[0], disp[0], tr);
      end
    end
    learn[0] = 1'b0;
    finish_hold(0, tr);
  endtask

  task automatic test_start_ignored();
    logic [15:0] tr, t2;
    int cnt, c;
    walk(0, 5'($urandom_range(0, 31)), 1'b1, tr, cnt);
    for (int i = 1; i < hold_c(0); i++) begin
      @(negedge clk);
      checks++;
      if (rt[0] !== 1'b0 || vis[0] !== 1'b1 || disp[0] !== tr) begin
        errors++;
        $display("FAIL start_in_hold: rt=%b vis=%b trace=%h, required 0 1 %h", rt[0], vis[0], disp[0], tr);
      end
    end
    @(negedge clk);
    checks++;
    if (dn[0] !== 1'b1 || rt[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_done_entry: done=%b rt=%b, required 1 0", dn[0], rt[0]);
    end
    osel[0] = 5'h0;
    @(negedge clk);
    start[0] = 1'b0;
    checks++;
    if (rt[0] !== 1'b1 || disp[0] !== 16'h0 || dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done: rt=%b trace=%h done=%b, required 1 0000 0", rt[0], disp[0], dn[0]);
    end
    c = int'(lfsr_m[0][3:0]);
    t2 = 16'h0;
    t2[c] = 1'b1;
    @(negedge clk);
    checks++;
    if (rt[0] !== 1'b0 || disp[0] !== t2 || org[0] !== {2'b00, 4'(c)}) begin
      errors++;
      $display("FAIL restart_origin: rt=%b trace=%h origin=%h, required 0 %h %h", rt[0], disp[0], org[0], t2, c);
    end
  endtask

  task automatic test_reset_mid_step();
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    checks++;
    if (disp[0] !== 16'h0 || rt[0] !== 1'b0 || org[0] !== 6'h3F || nxt[0] !== 6'h3F ||
        vis[0] !== 1'b0 || bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_step: trace=%h rt=%b origin=%h next=%h vis=%b busy=%b done=%b, required 0 0 3f 3f 0 0 0",
               disp[0], rt[0], org[0], nxt[0], vis[0], bsy[0], dn[0]);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b0 || disp[0] !== 16'h0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: done=%b busy=%b trace=%h, required 0 0 0000", i, dn[0], bsy[0], disp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_trace();
    test_corner();
    test_random_walks();
    test_learn();
    test_start_ignored();
    test_reset_mid_step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
